// File: rtl/seq_trigger_monitor.sv
// Ordered-pattern trigger monitor: advances through programmed match slots
// and, once the full sequence is seen, latches and rotates a signature register.
module seq_trigger_monitor #(
    parameter int DATA_W  = 128,
    parameter int STAGES  = 4,
    parameter int LEAK_W  = 128,
    parameter int STRICT  = 0,
    parameter int TIMEOUT = 0,
    localparam int IDX_W  = $clog2(STAGES),
    localparam int P_W    = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [DATA_W-1:0] cfg_pattern,
    input  logic              clear,
    output logic [P_W-1:0]    progress,
    output logic              triggered,
    output logic              trig_pulse,
    output logic [LEAK_W-1:0] leak_out
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    function automatic logic [LEAK_W-1:0] alt_pattern();
        logic [LEAK_W-1:0] v;
        for (int i = 0; i < LEAK_W; i++) begin
            v[i] = (i % 2) == 1;
        end
        return v;
    endfunction

    localparam logic [LEAK_W-1:0] LEAK_RST = alt_pattern();

    logic [DATA_W-1:0] pat_q [STAGES];
    logic [STAGES-1:0] en_q;
    logic [P_W-1:0]    p_q, p_d;
    logic              t_q, t_d;
    logic              pulse_q, pulse_d;
    logic [CNT_W-1:0]  c_q, c_d;
    logic [LEAK_W-1:0] l_q, l_d;
    logic              hit, hit0;

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                pat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (cfg_we && cfg_idx == IDX_W'(i)) begin
                    pat_q[i] <= cfg_pattern;
                    en_q[i]  <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        hit  = 1'b0;
        hit0 = en_q[0] && (in_data == pat_q[0]);
        for (int i = 0; i < STAGES; i++) begin
            if (p_q == P_W'(i)) begin
                hit = en_q[i] && (in_data == pat_q[i]);
            end
        end
    end

    always_comb begin
        p_d     = p_q;
        t_d     = t_q;
        c_d     = c_q;
        l_d     = l_q;
        pulse_d = 1'b0;
        if (clear) begin
            p_d = '0;
            t_d = 1'b0;
            c_d = '0;
            l_d = LEAK_RST;
        end else if (t_q) begin
            l_d = {l_q[0], l_q[LEAK_W-1:1]};
        end else if (in_valid && hit) begin
            p_d = p_q + 1'b1;
            c_d = '0;
            if (p_q == P_W'(STAGES - 1)) begin
                t_d     = 1'b1;
                pulse_d = 1'b1;
            end
        end else if (STRICT != 0 && in_valid && p_q != '0) begin
            p_d = hit0 ? P_W'(1) : '0;
            c_d = '0;
        end else if (TIMEOUT != 0 && p_q != '0) begin
            // the increment that would land on TIMEOUT-1 expires the sequence
            if (int'(c_q) + 1 >= TIMEOUT - 1) begin
                p_d = '0;
                c_d = '0;
            end else begin
                c_d = c_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q     <= '0;
            t_q     <= 1'b0;
            c_q     <= '0;
            pulse_q <= 1'b0;
            l_q     <= LEAK_RST;
        end else begin
            p_q     <= p_d;
            t_q     <= t_d;
            c_q     <= c_d;
            pulse_q <= pulse_d;
            l_q     <= l_d;
        end
    end

    assign progress   = p_q;
    assign triggered  = t_q;
    assign trig_pulse = pulse_q;
    assign leak_out   = l_q;

endmodule

// File: tb/tb_seq_trigger_monitor.sv
// Directed bench for seq_trigger_monitor: default, strict and timeout
// instances share one stimulus bus and are checked against hand values.
module tb_seq_trigger_monitor;

    localparam logic [127:0] K0   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K1   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] ZERO = 128'h0;
    localparam logic [127:0] ONE  = 128'h1;
    localparam logic [127:0] JUNK = 128'hdeadbeef0badf00dcafebabe12345678;
    localparam logic [127:0] ALTA = {32{4'hA}};
    localparam logic [127:0] ALT5 = {32{4'h5}};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_data;
    logic         cfg_we;
    logic [1:0]   cfg_idx;
    logic [127:0] cfg_pattern;
    logic         clear;

    logic [2:0]   p0, p1, p2;
    logic         t0, t1, t2;
    logic         pl0, pl1, pl2;
    logic [127:0] l0, l1, l2;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_trigger_monitor u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pattern(cfg_pattern),
        .clear(clear), .progress(p0), .triggered(t0),
        .trig_pulse(pl0), .leak_out(l0)
    );

    seq_trigger_monitor #(.STRICT(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pattern(cfg_pattern),
        .clear(clear), .progress(p1), .triggered(t1),
        .trig_pulse(pl1), .leak_out(l1)
    );

    seq_trigger_monitor #(.TIMEOUT(8)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pattern(cfg_pattern),
        .clear(clear), .progress(p2), .triggered(t2),
        .trig_pulse(pl2), .leak_out(l2)
    );

    typedef struct {
        logic         vld;
        logic [127:0] data;
        logic         clr;
        logic [2:0]   ep0;
        logic         et0;
        logic         epl0;
        logic [2:0]   ep1;
        logic         et1;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic [127:0] d,
                       input logic c, input logic [2:0] e_p0,
                       input logic e_t0, input logic e_pl0,
                       input logic [2:0] e_p1, input logic e_t1);
        vec_t r;
        r.vld  = v;
        r.data = d;
        r.clr  = c;
        r.ep0  = e_p0;
        r.et0  = e_t0;
        r.epl0 = e_pl0;
        r.ep1  = e_p1;
        r.et1  = e_t1;
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [127:0] d,
                         input logic c);
        in_valid = v;
        in_data  = d;
        clear    = c;
        cfg_we   = 1'b0;
        step();
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] idx, input logic [127:0] pat);
        in_valid    = 1'b0;
        cfg_we      = 1'b1;
        cfg_idx     = idx;
        cfg_pattern = pat;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic run_seq();
        drive(1, K0, 0);
        drive(1, K1, 0);
        drive(1, ZERO, 0);
        drive(1, ONE, 0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        cfg_we = 1'b0;
        cfg_idx = '0;
        cfg_pattern = '0;
        clear = 1'b0;
        step();
        step();
        chk("rst_progress", 128'(p0), 128'd0);
        chk("rst_triggered", 128'(t0), 128'd0);
        chk("rst_pulse", 128'(pl0), 128'd0);
        chk("rst_leak", l0, ALTA);
        rst = 1'b0;

        // zero patterns with enables cleared must not match
        drive(1, ZERO, 0);
        chk("noen_p0", 128'(p0), 128'd0);
        chk("noen_p1", 128'(p1), 128'd0);

        cfg(2'd0, K0);
        cfg(2'd1, K1);
        drive(1, K0, 0);
        chk("adv_p0", 128'(p0), 128'd1);

        // match against slot 1 while it is rewritten
        in_valid    = 1'b1;
        in_data     = K1;
        cfg_we      = 1'b1;
        cfg_idx     = 2'd1;
        cfg_pattern = JUNK;
        step();
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        chk("oldpat_p0", 128'(p0), 128'd2);
        chk("oldpat_p1", 128'(p1), 128'd2);

        drive(0, ZERO, 1);
        chk("clr_p0", 128'(p0), 128'd0);
        drive(1, K0, 0);
        drive(1, K1, 0);
        chk("newpat_p0", 128'(p0), 128'd1);
        chk("newpat_p1", 128'(p1), 128'd0);

        cfg(2'd1, K1);
        cfg(2'd2, ZERO);
        cfg(2'd3, ONE);

        add(0, ZERO, 1, 0, 0, 0, 0, 0);
        add(1, K0,   0, 1, 0, 0, 1, 0);
        add(1, K1,   0, 2, 0, 0, 2, 0);
        add(1, ZERO, 0, 3, 0, 0, 3, 0);
        add(1, ONE,  0, 4, 1, 1, 4, 1);
        add(0, ZERO, 0, 4, 1, 0, 4, 1);
        add(1, K0,   0, 4, 1, 0, 4, 1);
        add(0, ZERO, 1, 0, 0, 0, 0, 0);
        add(1, K0,   0, 1, 0, 0, 1, 0);
        add(1, JUNK, 0, 1, 0, 0, 0, 0);
        add(1, K1,   0, 2, 0, 0, 0, 0);
        add(0, K1,   0, 2, 0, 0, 0, 0);
        add(1, ZERO, 0, 3, 0, 0, 0, 0);
        add(1, JUNK, 0, 3, 0, 0, 0, 0);
        add(1, ONE,  0, 4, 1, 1, 0, 0);
        add(0, ZERO, 1, 0, 0, 0, 0, 0);
        add(1, K1,   0, 0, 0, 0, 0, 0);
        add(1, K0,   0, 1, 0, 0, 1, 0);
        add(1, K0,   0, 1, 0, 0, 1, 0);
        add(0, K1,   0, 1, 0, 0, 1, 0);
        add(1, K0,   1, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].vld, tbl[i].data, tbl[i].clr);
            chk($sformatf("v%0d_p0", i), 128'(p0), 128'(tbl[i].ep0));
            chk($sformatf("v%0d_t0", i), 128'(t0), 128'(tbl[i].et0));
            chk($sformatf("v%0d_pl0", i), 128'(pl0), 128'(tbl[i].epl0));
            chk($sformatf("v%0d_p1", i), 128'(p1), 128'(tbl[i].ep1));
            chk($sformatf("v%0d_t1", i), 128'(t1), 128'(tbl[i].et1));
        end

        // signature rotation while triggered, then clear and re-arm
        drive(0, ZERO, 1);
        run_seq();
        chk("trig_t0", 128'(t0), 128'd1);
        chk("trig_pl0", 128'(pl0), 128'd1);
        chk("trig_leak", l0, ALTA);
        drive(0, ZERO, 0);
        chk("rot1_leak", l0, ALT5);
        chk("rot1_pl0", 128'(pl0), 128'd0);
        repeat (127) drive(0, ZERO, 0);
        chk("rot128_leak", l0, ALTA);
        chk("rot128_t0", 128'(t0), 128'd1);
        chk("rot128_p0", 128'(p0), 128'd4);
        drive(0, ZERO, 1);
        chk("clr_t0", 128'(t0), 128'd0);
        chk("clr_p0b", 128'(p0), 128'd0);
        chk("clr_leak", l0, ALTA);
        run_seq();
        chk("retrig_t0", 128'(t0), 128'd1);
        chk("retrig_pl0", 128'(pl0), 128'd1);

        // strict restart from P=2 on a slot-0 value
        drive(0, ZERO, 1);
        drive(1, K0, 0);
        drive(1, K1, 0);
        chk("strict_p2", 128'(p1), 128'd2);
        drive(1, K0, 0);
        chk("strict_restart", 128'(p1), 128'd1);
        drive(1, JUNK, 0);
        chk("strict_drop", 128'(p1), 128'd0);

        // timeout window of 8
        drive(0, ZERO, 1);
        drive(1, K0, 0);
        chk("to_adv", 128'(p2), 128'd1);
        repeat (6) drive(0, ZERO, 0);
        chk("to_idle6", 128'(p2), 128'd1);
        drive(0, ZERO, 0);
        chk("to_expire", 128'(p2), 128'd0);
        drive(1, K0, 0);
        repeat (6) drive(0, ZERO, 0);
        drive(1, K1, 0);
        chk("to_inwin", 128'(p2), 128'd2);
        chk("noto_p0", 128'(p0), 128'd2);

        // reset while triggered drops config as well
        drive(1, ZERO, 0);
        drive(1, ONE, 0);
        chk("pre_rst_t0", 128'(t0), 128'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_t0", 128'(t0), 128'd0);
        chk("mid_rst_p0", 128'(p0), 128'd0);
        chk("mid_rst_leak", l0, ALTA);
        drive(1, K0, 0);
        chk("rst_noen_p0", 128'(p0), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_trigger_monitor.md
SEQ_TRIGGER_MONITOR -- requirements
Module: seq_trigger_monitor

Interface
REQ-001 Parameter DATA_W, 128, width of the monitored data word.
REQ-002 Parameter STAGES, 4, number of ordered patterns in the trigger sequence (2..16).
REQ-003 Parameter LEAK_W, 128, width of the signature rotate register.
REQ-004 Parameter STRICT, 0, mismatch policy: 0 = mismatches ignored, 1 = a mismatch restarts the sequence.
REQ-005 Parameter TIMEOUT, 0, maximum cycles between successive matches; 0 disables the timeout.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 in_valid  input  1  in_data is sampled this cycle.
REQ-009 in_data  input  DATA_W  monitored data word.
REQ-010 cfg_we  input  1  write cfg_pattern into slot cfg_idx and set that slot's enable bit.
REQ-011 cfg_idx  input  clog2(STAGES)  pattern slot index; writes with cfg_idx >= STAGES are ignored.
REQ-012 cfg_pattern  input  DATA_W  pattern value.
REQ-013 clear  input  1  synchronous clear of progress, trigger and signature register; patterns are kept.
REQ-014 progress  output  clog2(STAGES+1)  number of stages matched so far.
REQ-015 triggered  output  1  sticky flag: full sequence seen.
REQ-016 trig_pulse  output  1  one-cycle pulse in the first cycle triggered is high.
REQ-017 leak_out  output  LEAK_W  signature register contents.

Function
REQ-018 State: progress counter P, triggered flag T, timeout counter C, signature register L, STAGES pattern/enable pairs.
REQ-019 Advance: if T=0, in_valid=1, enable[P]=1 and in_data==pattern[P], then P increments and C clears at the next edge.
REQ-020 If P becomes STAGES, T=1 at that same edge; trig_pulse=1 for exactly that one cycle; latency from the final matching sample to triggered is 1 cycle.
REQ-021 A slot with enable=0 never matches.
REQ-022 STRICT=0: non-matching valid samples leave P unchanged.
REQ-023 STRICT=1, non-matching valid sample with P>0: P becomes 1 if in_data matches enabled pattern[0], otherwise P becomes 0; C clears.
REQ-024 TIMEOUT>0: when 0<P<STAGES and T=0, C increments every cycle without an advance; when C reaches TIMEOUT-1 without an advance, P and C become 0 at the next edge.
REQ-025 While T=1: in_valid is ignored, P holds STAGES, and L rotates right by one bit per cycle ({L[0], L[LEAK_W-1:1]}).
REQ-026 While T=0: L holds its value.
REQ-027 Config writes take effect at the next edge; a match in the same cycle as a write to that slot uses the old pattern and enable.
REQ-028 Precedence: rst > clear > advance/restart/timeout > hold.
REQ-029 Equality compare is full DATA_W width; there are no masks.

Reset
REQ-030 On rst=1 at a clock edge: P=0, T=0, C=0, trig_pulse=0, all enable bits=0, all patterns=0.
REQ-031 On rst=1 at a clock edge: L = alternating pattern with bit i = (i mod 2), i.e. 0xAAAA... for LEAK_W=128.
REQ-032 clear=1 restores P, T, C, trig_pulse and L to their reset values, leaving patterns and enables intact.
REQ-033 rst or clear asserted mid-sequence or while triggered takes effect at that edge; there is no partial state.

Verification
REQ-034 Defaults. Program slots 0..3 with 3243f6a8885a308d313198a2e0370734, 00112233445566778899aabbccddeeff, 0, 1. Drive those values in order on in_valid -> progress steps 1,2,3,4; triggered and trig_pulse high one cycle after the 4th sample; leak_out = 0x5555... the following cycle.
REQ-035 STRICT=0. Sequence slot0, junk, slot1, slot2, slot3 -> triggers. Same stimulus with STRICT=1 -> progress returns to 0 after junk and no trigger occurs.
REQ-036 STRICT=1, P=2. Drive the slot0 value -> progress=1 at the next edge.
REQ-037 TIMEOUT=8. Match slot0, then idle 7 cycles -> progress=0. Match slot0, idle 6 cycles, then match slot1 -> progress=2.
REQ-038 Triggered. Run 128 cycles -> leak_out returns to 0xAAAA...; assert clear -> triggered=0 and progress=0; the sequence re-triggers without reprogramming.
REQ-039 Slot with enable=0 (fresh reset, no config). Drive all-zero data -> progress stays 0. A cfg write to slot 1 in the same cycle as a matching slot-1 sample -> old pattern is used for that compare.
